bsg_cache_req_arbiter: RTL and testbench

- Shares one bsg_cache instance between num_req_p requesters.
- Each requester has its own cache-packet ready/valid input channel and its own response output channel.
- Requests are granted round-robin. The requester ID of every accepted packet is queued in an internal tag FIFO.
- The cache returns responses in order, so each response is steered back to the requester at the FIFO head.

---
 rtl/bsg_cache_req_arbiter.sv | 146 ++++++++++++++
 tb/tb_bsg_cache_req_arbiter.sv | 613 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_req_arbiter.sv
// bsg_cache_req_arbiter: shares one bsg_cache among num_req_p requesters.
// Round-robin request grant; in-order responses steered via a tag FIFO.
module bsg_cache_req_arbiter #(
    parameter int num_req_p    = 4,
    parameter int pkt_width_p  = 68,
    parameter int data_width_p = 32,
    parameter int max_out_p    = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
    input  logic [num_req_p-1:0]             req_v_i,
    output logic [num_req_p-1:0]             req_ready_o,
    output logic [data_width_p-1:0]          resp_data_o,
    output logic [num_req_p-1:0]             resp_v_o,
    input  logic [num_req_p-1:0]             resp_yumi_i,
    output logic [pkt_width_p-1:0]           cache_pkt_o,
    output logic                             cache_v_o,
    input  logic                             cache_ready_i,
    input  logic [data_width_p-1:0]          cache_data_i,
    input  logic                             cache_v_i,
    output logic                             cache_yumi_o
);

    localparam int tag_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w_lp = $clog2(max_out_p + 1);
    localparam int ptr_w_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1;

    localparam logic [cnt_w_lp-1:0] max_cnt_lp  = cnt_w_lp'(max_out_p);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(max_out_p - 1);
    localparam logic [tag_w_lp-1:0] last_req_lp = tag_w_lp'(num_req_p - 1);
    localparam logic [tag_w_lp:0]   num_req_lp  = (tag_w_lp + 1)'(num_req_p);

    logic [tag_w_lp-1:0] prio_q, prio_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [tag_w_lp-1:0] tags_q [max_out_p];
    logic [tag_w_lp-1:0] tags_d [max_out_p];

    logic [2*num_req_p-1:0] v_dbl;
    logic [num_req_p-1:0]   v_rot;
    logic [tag_w_lp-1:0]    offs;
    logic [tag_w_lp:0]      gsum;
    logic [tag_w_lp-1:0]    grant;

    logic                   any_v;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   resp_live;
    logic [tag_w_lp-1:0]    head;

    assign any_v = |req_v_i;
    assign full  = (cnt_q == max_cnt_lp);
    assign empty = (cnt_q == '0);
    assign head  = tags_q[rptr_q];

    // Rotate valids so the pointer sits at bit 0, then take the nearest one.
    always_comb begin
        v_dbl = {req_v_i, req_v_i} >> prio_q;
        v_rot = v_dbl[num_req_p-1:0];
        offs  = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (v_rot[k]) offs = tag_w_lp'(k);
        end
        gsum = {1'b0, prio_q} + {1'b0, offs};
        if (gsum >= num_req_lp) gsum = gsum - num_req_lp;
        grant = gsum[tag_w_lp-1:0];
    end

    // Request path is a pure pass-through of the granted requester.
    always_comb begin
        cache_pkt_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant == tag_w_lp'(i)) begin
                cache_pkt_o = req_pkt_i[i*pkt_width_p +: pkt_width_p];
            end
        end
    end

    assign cache_v_o   = any_v & ~full & ~reset_i;
    assign push        = cache_v_o & cache_ready_i;
    assign req_ready_o = push ? (num_req_p'(1) << grant) : '0;

    assign resp_live    = cache_v_i & ~empty & ~reset_i;
    assign resp_data_o  = cache_data_i;
    assign resp_v_o     = resp_live ? (num_req_p'(1) << head) : '0;
    assign cache_yumi_o = resp_live & resp_yumi_i[head];
    assign pop          = cache_yumi_o;

    // Next state for the priority pointer and the tag FIFO.
    always_comb begin
        tags_d = tags_q;
        prio_d = prio_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            tags_d[wptr_q] = grant;
            wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
            prio_d = (grant == last_req_lp) ? '0 : grant + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset drops every outstanding tag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_q <= '0;
            cnt_q  <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
            for (int i = 0; i < max_out_p; i++) begin
                tags_q[i] <= '0;
            end
        end else begin
            prio_q <= prio_d;
            cnt_q  <= cnt_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            tags_q <= tags_d;
        end
    end

`ifndef SYNTHESIS
    // Catch orphan cache responses and any push into a full tag FIFO.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(cache_v_i && empty))
                else $error("cache response with no outstanding request");
            assert (!(push && full))
                else $error("push into full tag FIFO");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_cache_req_arbiter.sv
// tb_bsg_cache_req_arbiter: directed and random checks of the arbiter
// against a queue-based model and a simple in-order cache model.
module tb_bsg_cache_req_arbiter;

    localparam int N  = 4;
    localparam int PW = 68;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam logic [3:0] OP_LW = 4'd1;
    localparam logic [3:0] OP_SW = 4'd2;

    typedef struct {
        int          id;
        logic [31:0] data;
    } ent_t;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N*PW-1:0] req_pkt_i;
    logic [N-1:0]    req_v_i;
    logic [N-1:0]    req_ready_o;
    logic [DW-1:0]   resp_data_o;
    logic [N-1:0]    resp_v_o;
    logic [N-1:0]    resp_yumi_i;
    logic [PW-1:0]   cache_pkt_o;
    logic            cache_v_o;
    logic            cache_ready_i;
    logic [DW-1:0]   cache_data_i;
    logic            cache_v_i;
    logic            cache_yumi_o;

    int n_chk = 0;
    int n_fail = 0;

    ent_t        mq[$];
    logic [31:0] cq[$];
    logic [31:0] mem [256];
    int          ptr_m = 0;

    logic        exp_cv;
    logic        exp_yumi;
    int          exp_grant;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;

    always #5 clk = ~clk;

    bsg_cache_req_arbiter #(
        .num_req_p   (N),
        .pkt_width_p (PW),
        .data_width_p(DW),
        .max_out_p   (MO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_pkt_i    (req_pkt_i),
        .req_v_i      (req_v_i),
        .req_ready_o  (req_ready_o),
        .resp_data_o  (resp_data_o),
        .resp_v_o     (resp_v_o),
        .resp_yumi_i  (resp_yumi_i),
        .cache_pkt_o  (cache_pkt_o),
        .cache_v_o    (cache_v_o),
        .cache_ready_i(cache_ready_i),
        .cache_data_i (cache_data_i),
        .cache_v_i    (cache_v_i),
        .cache_yumi_o (cache_yumi_o)
    );

    function automatic logic [PW-1:0] mk_pkt(logic [3:0] op, logic [31:0] a,
                                             logic [31:0] d);
        return {op, a, d};
    endfunction

    function automatic logic [PW-1:0] slice(int i);
        return req_pkt_i[i*PW +: PW];
    endfunction

    function automatic logic [31:0] cache_fn(logic [PW-1:0] p);
        if (p[67:64] == OP_LW) return mem[p[41:34]];
        return 32'h0;
    endfunction

    task automatic mem_wr(input logic [PW-1:0] p);
        if (p[67:64] == OP_SW) mem[p[41:34]] = p[31:0];
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) begin
            mem[i] = {4'(i / 64), 20'h0, 8'(i % 64)};
        end
    endtask

    task automatic drive_cache(input bit en);
        cache_v_i    = en && (cq.size() > 0);
        cache_data_i = (cq.size() > 0) ? cq[0] : 32'h0;
    endtask

    // Reference: nearest valid requester at or after the pointer, in-order tags.
    task automatic model_eval();
        int best;
        int d;
        best = N;
        exp_grant = 0;
        for (int i = 0; i < N; i++) begin
            d = (i - ptr_m + N) % N;
            if (req_v_i[i] && d < best) begin
                best = d;
                exp_grant = i;
            end
        end
        exp_cv = (best < N) && (mq.size() < MO) && !reset_i;
        exp_ready = '0;
        if (exp_cv && cache_ready_i) exp_ready[exp_grant] = 1'b1;
        exp_rv = '0;
        exp_yumi = 1'b0;
        if (cache_v_i && mq.size() > 0 && !reset_i) begin
            exp_rv[mq[0].id] = 1'b1;
            exp_yumi = resp_yumi_i[mq[0].id];
        end
    endtask

    task automatic tick();
        ent_t e;
        if (reset_i) begin
            mq.delete();
            cq.delete();
            ptr_m = 0;
        end else begin
            if (exp_yumi) void'(mq.pop_front());
            if (exp_cv && cache_ready_i) begin
                e.id = exp_grant;
                e.data = cache_fn(slice(exp_grant));
                mq.push_back(e);
                ptr_m = (exp_grant + 1) % N;
            end
            if (cache_yumi_o && cq.size() > 0) void'(cq.pop_front());
            if (cache_v_o && cache_ready_i) begin
                cq.push_back(cache_fn(cache_pkt_o));
                mem_wr(cache_pkt_o);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        req_v_i = '0;
        resp_yumi_i = '0;
        cache_ready_i = 1'b0;
        cache_v_i = 1'b0;
        model_eval();
        tick();
        model_eval();
        tick();
        reset_i = 1'b0;
        drive_cache(1'b0);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        req_v_i = '1;
        cache_ready_i = 1'b1;
        cache_v_i = 1'b1;
        cache_data_i = 32'hDEAD_BEEF;
        resp_yumi_i = '1;
        for (int i = 0; i < N; i++) req_pkt_i[i*PW +: PW] = mk_pkt(OP_LW, 32'(i * 256), 0);
        @(posedge clk);
        #2;
        n_chk++;
        if (req_ready_o !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0000", req_ready_o);
        end
        n_chk++;
        if (resp_v_o !== '0) begin
            n_fail++;
            $display("FAIL reset_resp_v: got %b want 0000", resp_v_o);
        end
        n_chk++;
        if (cache_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cache_v: got %b want 0", cache_v_o);
        end
        n_chk++;
        if (cache_yumi_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cache_yumi: got %b want 0", cache_yumi_o);
        end
        do_reset();
    endtask

    task automatic test_single();
        int acc;
        int got;
        logic [31:0] want [3];
        acc = 0;
        got = 0;
        want[0] = 32'hA0;
        want[1] = 32'hA1;
        want[2] = 32'hA2;
        do_reset();
        preload();
        mem[4] = 32'hA0;
        mem[5] = 32'hA1;
        mem[6] = 32'hA2;
        cache_ready_i = 1'b1;
        resp_yumi_i = 4'b0100;
        for (int c = 0; c < 30 && got < 3; c++) begin
            req_v_i = (acc < 3) ? 4'b0100 : 4'b0000;
            req_pkt_i[2*PW +: PW] = mk_pkt(OP_LW, 32'(16 + 4 * acc), 0);
            drive_cache(1'b1);
            #1;
            model_eval();
            if (acc < 3) begin
                n_chk++;
                if (cache_v_o !== 1'b1 || cache_pkt_o !== slice(2)) begin
                    n_fail++;
                    $display("FAIL single_pkt: got v=%b %h want v=1 %h",
                             cache_v_o, cache_pkt_o, slice(2));
                end
            end
            if (exp_yumi) begin
                n_chk++;
                if (resp_v_o !== 4'b0100 || resp_data_o !== want[got]) begin
                    n_fail++;
                    $display("FAIL single_resp: got v=%b d=%h want v=0100 d=%h",
                             resp_v_o, resp_data_o, want[got]);
                end
                got++;
            end
            if (exp_cv && cache_ready_i) acc++;
            tick();
        end
        n_chk++;
        if (got !== 3) begin
            n_fail++;
            $display("FAIL single_count: got %0d responses want 3", got);
        end
    endtask

    task automatic test_round_robin();
        int seq [8];
        int cnt [N];
        int acc;
        int got;
        logic [N-1:0] want;
        acc = 0;
        got = 0;
        for (int i = 0; i < 8; i++) seq[i] = i % 4;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        do_reset();
        preload();
        cache_ready_i = 1'b1;
        resp_yumi_i = '1;
        for (int c = 0; c < 60 && (acc < 8 || got < 8); c++) begin
            req_v_i = (acc < 8) ? 4'hF : 4'h0;
            for (int i = 0; i < N; i++) begin
                req_pkt_i[i*PW +: PW] = mk_pkt(OP_LW, 32'(i * 256 + 4 * cnt[i]), 0);
            end
            drive_cache(1'b1);
            #1;
            model_eval();
            if (acc < 8) begin
                want = '0;
                want[seq[acc]] = 1'b1;
                n_chk++;
                if (req_ready_o !== want) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: got %b want %b", acc, req_ready_o, want);
                end
            end
            if (exp_yumi && got < 8) begin
                want = '0;
                want[seq[got]] = 1'b1;
                n_chk++;
                if (resp_v_o !== want || resp_data_o[31:28] !== 4'(seq[got])) begin
                    n_fail++;
                    $display("FAIL rr_route%0d: got v=%b d=%h want v=%b tag=%0d",
                             got, resp_v_o, resp_data_o, want, seq[got]);
                end
                got++;
            end
            for (int i = 0; i < N; i++) if (req_ready_o[i]) cnt[i]++;
            if (|req_ready_o) acc++;
            tick();
        end
        n_chk++;
        if (got !== 8 || acc !== 8) begin
            n_fail++;
            $display("FAIL rr_count: got acc=%0d resp=%0d want 8/8", acc, got);
        end
    endtask

    task automatic test_full();
        logic [N-1:0] want;
        do_reset();
        preload();
        req_v_i = 4'hF;
        for (int i = 0; i < N; i++) req_pkt_i[i*PW +: PW] = mk_pkt(OP_LW, 32'(i * 256), 0);
        cache_ready_i = 1'b1;
        resp_yumi_i = '0;
        for (int k = 0; k < 4; k++) begin
            drive_cache(1'b1);
            #1;
            model_eval();
            want = '0;
            want[k] = 1'b1;
            n_chk++;
            if (cache_v_o !== 1'b1 || req_ready_o !== want) begin
                n_fail++;
                $display("FAIL full_fill%0d: got v=%b r=%b want v=1 r=%b",
                         k, cache_v_o, req_ready_o, want);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive_cache(1'b1);
            #1;
            model_eval();
            n_chk++;
            if (cache_v_o !== 1'b0 || req_ready_o !== '0) begin
                n_fail++;
                $display("FAIL full_block%0d: got v=%b r=%b want v=0 r=0000",
                         k, cache_v_o, req_ready_o);
            end
            tick();
        end
        resp_yumi_i = 4'b0001;
        drive_cache(1'b1);
        #1;
        model_eval();
        n_chk++;
        if (cache_yumi_o !== 1'b1 || cache_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop: got yumi=%b v=%b want yumi=1 v=0",
                     cache_yumi_o, cache_v_o);
        end
        tick();
        resp_yumi_i = '0;
        drive_cache(1'b1);
        #1;
        model_eval();
        n_chk++;
        if (cache_v_o !== 1'b1 || req_ready_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL full_reopen: got v=%b r=%b want v=1 r=0001",
                     cache_v_o, req_ready_o);
        end
        tick();
        drive_cache(1'b1);
        #1;
        model_eval();
        n_chk++;
        if (cache_v_o !== 1'b0 || cache_yumi_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_again: got v=%b yumi=%b want v=0 yumi=0",
                     cache_v_o, cache_yumi_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] pb;
        do_reset();
        preload();
        req_v_i = 4'b0010;
        req_pkt_i[1*PW +: PW] = mk_pkt(OP_LW, 32'h100, 0);
        cache_ready_i = 1'b1;
        resp_yumi_i = '1;
        drive_cache(1'b1);
        #1;
        model_eval();
        n_chk++;
        if (req_ready_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_setup: got %b want 0010", req_ready_o);
        end
        tick();
        req_v_i = '0;
        for (int c = 0; c < 10 && cq.size() > 0; c++) begin
            drive_cache(1'b1);
            #1;
            model_eval();
            tick();
        end
        n_chk++;
        if (cq.size() !== 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d pending want 0", cq.size());
        end
        pb = mk_pkt(OP_LW, 32'h304, 0);
        req_pkt_i[1*PW +: PW] = mk_pkt(OP_LW, 32'h104, 0);
        req_pkt_i[3*PW +: PW] = pb;
        req_v_i = 4'b1010;
        cache_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_cache(1'b1);
            #1;
            model_eval();
            n_chk++;
            if (cache_v_o !== 1'b1 || req_ready_o !== '0 || cache_pkt_o !== pb) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got v=%b r=%b p=%h want v=1 r=0000 p=%h",
                         k, cache_v_o, req_ready_o, cache_pkt_o, pb);
            end
            tick();
        end
        cache_ready_i = 1'b1;
        drive_cache(1'b1);
        #1;
        model_eval();
        n_chk++;
        if (req_ready_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_accept: got %b want 1000", req_ready_o);
        end
        tick();
        req_pkt_i[0*PW +: PW] = mk_pkt(OP_LW, 32'h004, 0);
        req_v_i = 4'b1011;
        drive_cache(1'b1);
        #1;
        model_eval();
        n_chk++;
        if (req_ready_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_ptr0: got %b want 0001", req_ready_o);
        end
        tick();
        req_v_i = '0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] want;
        do_reset();
        preload();
        req_v_i = 4'hF;
        for (int i = 0; i < N; i++) req_pkt_i[i*PW +: PW] = mk_pkt(OP_LW, 32'(i * 256), 0);
        cache_ready_i = 1'b1;
        resp_yumi_i = '0;
        for (int k = 0; k < 3; k++) begin
            drive_cache(1'b1);
            #1;
            model_eval();
            tick();
        end
        reset_i = 1'b1;
        drive_cache(1'b1);
        resp_yumi_i = '1;
        #1;
        model_eval();
        n_chk++;
        if (req_ready_o !== '0 || resp_v_o !== '0 ||
            cache_v_o !== 1'b0 || cache_yumi_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outs: got r=%b rv=%b v=%b y=%b want all 0",
                     req_ready_o, resp_v_o, cache_v_o, cache_yumi_o);
        end
        tick();
        reset_i = 1'b0;
        resp_yumi_i = '0;
        for (int k = 0; k < 4; k++) begin
            drive_cache(1'b0);
            #1;
            model_eval();
            want = '0;
            want[k] = 1'b1;
            n_chk++;
            if (cache_v_o !== 1'b1 || req_ready_o !== want) begin
                n_fail++;
                $display("FAIL mid_refill%0d: got v=%b r=%b want v=1 r=%b",
                         k, cache_v_o, req_ready_o, want);
            end
            tick();
        end
        drive_cache(1'b0);
        #1;
        model_eval();
        n_chk++;
        if (cache_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_full: got v=%b want 0", cache_v_o);
        end
        tick();
    endtask

    task automatic test_random();
        bit pend [N];
        int sent [N];
        int recv [N];
        do_reset();
        preload();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            sent[i] = 0;
            recv[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    req_pkt_i[i*PW +: PW] = mk_pkt(
                        ($urandom_range(0, 1) == 1) ? OP_LW : OP_SW,
                        32'(i * 256 + 4 * $urandom_range(0, 63)),
                        {4'(i), 28'($urandom)});
                end
                req_v_i[i] = pend[i];
            end
            cache_ready_i = ($urandom_range(0, 3) != 0);
            resp_yumi_i = N'($urandom);
            drive_cache($urandom_range(0, 2) != 0);
            #1;
            model_eval();
            n_chk++;
            if (cache_v_o !== exp_cv) begin
                n_fail++;
                $display("FAIL rnd_cache_v@%0d: got %b want %b", c, cache_v_o, exp_cv);
            end
            n_chk++;
            if (req_ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL rnd_ready@%0d: got %b want %b", c, req_ready_o, exp_ready);
            end
            if (exp_cv) begin
                n_chk++;
                if (cache_pkt_o !== slice(exp_grant)) begin
                    n_fail++;
                    $display("FAIL rnd_pkt@%0d: got %h want %h",
                             c, cache_pkt_o, slice(exp_grant));
                end
            end
            n_chk++;
            if (resp_v_o !== exp_rv) begin
                n_fail++;
                $display("FAIL rnd_resp_v@%0d: got %b want %b", c, resp_v_o, exp_rv);
            end
            n_chk++;
            if (cache_yumi_o !== exp_yumi) begin
                n_fail++;
                $display("FAIL rnd_yumi@%0d: got %b want %b", c, cache_yumi_o, exp_yumi);
            end
            if (exp_yumi) begin
                n_chk++;
                if (resp_data_o !== mq[0].data) begin
                    n_fail++;
                    $display("FAIL rnd_data@%0d: got %h want %h", c, resp_data_o, mq[0].data);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready_o[i]) begin
                    pend[i] = 1'b0;
                    sent[i]++;
                end
                if (cache_yumi_o && resp_v_o[i]) recv[i]++;
            end
            tick();
        end
        req_v_i = '0;
        resp_yumi_i = '1;
        cache_ready_i = 1'b1;
        for (int c = 0; c < 100 && cq.size() > 0; c++) begin
            drive_cache(1'b1);
            #1;
            model_eval();
            for (int i = 0; i < N; i++) begin
                if (cache_yumi_o && resp_v_o[i]) recv[i]++;
            end
            tick();
        end
        drive_cache(1'b0);
        for (int i = 0; i < N; i++) begin
            n_chk++;
            if (sent[i] !== recv[i] || sent[i] == 0) begin
                n_fail++;
                $display("FAIL rnd_sent_recv%0d: got recv=%0d want sent=%0d (nonzero)",
                         i, recv[i], sent[i]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b1;
        req_pkt_i = '0;
        req_v_i = '0;
        resp_yumi_i = '0;
        cache_ready_i = 1'b0;
        cache_data_i = '0;
        cache_v_i = 1'b0;
        exp_cv = 1'b0;
        exp_yumi = 1'b0;
        exp_grant = 0;
        exp_ready = '0;
        exp_rv = '0;
        preload();
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
